// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/clear controller and 1/100 s time base for the stopwatch.
//
// Divides the system clock down to a tick of TICK_HZ and advances a cascaded
// msec/sec/min counter on each tick while running. o_msec feeds the dot-blink
// comparator; o_sec/o_min feed the FND digit splitter.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous reset, active-low
//   i_btn_run    in   1  debounced 1-cycle pulse, toggles RUN/STOP
//   i_btn_clear  in   1  debounced 1-cycle pulse, clears time while stopped
//   o_msec       out  7  centiseconds, 0..MSEC_MAX-1
//   o_sec        out  6  seconds, 0..SEC_MAX-1
//   o_min        out  6  minutes, 0..MIN_MAX-1
//   o_running    out  1  high while in RUN
//   o_tick       out  1  1-cycle pulse, same cycle the counters advance
//   o_wrap       out  1  1-cycle pulse when the time rolls over to 00:00.00
module stopwatch_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int MSEC_MAX = 100,
    parameter int SEC_MAX  = 60,
    parameter int MIN_MAX  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic       o_running,
    output logic       o_tick,
    output logic       o_wrap
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int DW  = $clog2(DIV);

    localparam logic [1:0] S_STOP  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [6:0]    MSEC_LAST = 7'(MSEC_MAX - 1);
    localparam logic [5:0]    SEC_LAST  = 6'(SEC_MAX - 1);
    localparam logic [5:0]    MIN_LAST  = 6'(MIN_MAX - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [DW-1:0] r_div;
    logic [6:0]    r_msec;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic          r_running;
    logic          r_tick;
    logic          r_wrap;
    logic          w_tick_en;
    logic          w_msec_c;
    logic          w_sec_c;
    logic          w_min_c;

    // Clear has priority over run in STOP; clear is ignored in RUN; CLEAR lasts one cycle.
    // The unused encoding behaves like STOP so the FSM always recovers.
    assign w_state_nxt = (r_state == S_CLEAR) ? S_STOP :
                         (r_state == S_RUN)   ? (i_btn_run ? S_STOP : S_RUN) :
                         i_btn_clear          ? S_CLEAR :
                         i_btn_run            ? S_RUN : S_STOP;

    // Tick is decided on the current state, so a tick due on the RUN->STOP cycle is still taken.
    assign w_tick_en = (r_state == S_RUN) && (r_div == DIV_LAST);
    assign w_msec_c  = w_tick_en && (r_msec == MSEC_LAST);
    assign w_sec_c   = w_msec_c && (r_sec == SEC_LAST);
    assign w_min_c   = w_sec_c && (r_min == MIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_STOP;
            r_div     <= '0;
            r_msec    <= '0;
            r_sec     <= '0;
            r_min     <= '0;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_tick    <= w_tick_en;
            r_wrap    <= w_min_c;
            if (r_state == S_CLEAR) begin
                r_div  <= '0;
                r_msec <= '0;
                r_sec  <= '0;
                r_min  <= '0;
            end else if (r_state == S_RUN) begin
                // Divider holds outside RUN so the sub-tick phase survives a pause.
                r_div <= w_tick_en ? '0 : r_div + 1'b1;
                if (w_tick_en) r_msec <= w_msec_c ? '0 : r_msec + 1'b1;
                if (w_msec_c) r_sec <= w_sec_c ? '0 : r_sec + 1'b1;
                if (w_sec_c) r_min <= w_min_c ? '0 : r_min + 1'b1;
            end
        end
    end

    assign o_msec    = r_msec;
    assign o_sec     = r_sec;
    assign o_min     = r_min;
    assign o_running = r_running;
    assign o_tick    = r_tick;
    assign o_wrap    = r_wrap;
endmodule
